dual_port_ram: RTL and testbench
================================

// Module: dual_port_ram
// PURPOSE
//   Parametrised successor to the single-word scratch RAM: one read/write port (A) and
//   one read-only port (B) with req/valid handshakes, byte-lane write enables, a 1- or 2-
//   cycle read pipeline, and hardware clear after reset. Serves as CPU data/instruction memory.
//   Port A carries loads/stores. Port B carries instruction fetch or debug reads.
// PARAMETERS
//   DATA_WIDTH     32   word width in bits; must be a multiple of 8
//   DEPTH          512  number of words
//   ADDRESS_WIDTH  32   width of addrA/addrB (word address)
//   READ_LATENCY   1    cycles from accepted request to valid; legal values 1 or 2
// PORTS
//   clk         in   1              clock, all logic on posedge
//   reset       in   1              asynchronous, active-high
//   reqA        in   1              port A request
//   weA         in   1              port A write (1) / read (0); sampled with reqA
//   addrA       in   ADDRESS_WIDTH  port A word address
//   dataInA     in   DATA_WIDTH     port A write data
//   byteEnA     in   DATA_WIDTH/8   port A byte-lane write enables (bit i -> bits 8i+7:8i)
//   readyA      out  1              port A can accept a request this cycle
//   validA      out  1              1-cycle pulse: outA/errA hold the result of a request
//   outA        out  DATA_WIDTH     port A read data, or merged word after a write
//   errA        out  1              qualified by validA: address >= DEPTH
//   reqB        in   1              port B read request
//   addrB       in   ADDRESS_WIDTH  port B word address
//   readyB      out  1              port B can accept a request this cycle
//   validB      out  1              1-cycle pulse: outB/errB valid
//   outB        out  DATA_WIDTH     port B read data
//   errB        out  1              qualified by validB: address >= DEPTH
//   clearing    out  1              high while the post-reset clear is running
// BEHAVIOUR
//   Reset (async): all outputs 0 except clearing=1. The FSM enters CLEAR. Pipelines are flushed.
//     No valid pulse is emitted for any request in flight.
//   FSM: CLEAR -> READY. In CLEAR, one word is zeroed per cycle at clear address 0..DEPTH-1.
//     The FSM enters READY on the cycle after word DEPTH-1 is written.
//     Reset asserted mid-CLEAR restarts the clear from address 0.
//   readyA = readyB = (state == READY). clearing = (state == CLEAR).
//     Requests are ignored while not ready and are never queued.
//   Accept: a request is accepted when req && ready at the posedge. Both ports may accept every cycle.
//   Latency: validX rises exactly READ_LATENCY cycles after the accepting edge. Results emerge in order.
//     No backpressure on outputs.
//   Read: outX = memory[addr] as of the accept edge.
//   Write (A): each lane with byteEnA=1 is updated. outA = resulting merged word (write-first).
//     validA pulses with the same latency. A write with byteEnA=0 is legal; memory is unchanged.
//   Collision: A writes addr N and B reads addr N on the same edge. B returns the new merged word
//     via the bypass path.
//   Out of range (addr >= DEPTH, full ADDRESS_WIDTH compared): the write is dropped, out=0, err=1
//     with valid. The memory index is never evaluated out of range.
//   outX and errX hold their values between valid pulses. Only validX is a pulse.
// TESTING
//   1 Reset for 3 cycles, release -> clearing=1 for exactly DEPTH cycles, then readyA=readyB=1.
//     A full readback returns 0 at every address.
//   2 Write A addr 5 = 0xDEADBEEF with byteEn=0xF, then byteEn=0x2 data 0x00001200
//     -> read addr 5 returns 0xDEAD12EF. validA appears at +READ_LATENCY each time.
//   3 Same edge: A writes addr 7 = 0xCAFEF00D, B reads addr 7 -> outB=0xCAFEF00D with validB.
//   4 Back-to-back reads on A for addrs 0,1,2,3 (preloaded 0x10..0x13), run with both
//     READ_LATENCY=1 and READ_LATENCY=2 -> four consecutive validA pulses giving 0x10,0x11,0x12,0x13.
//   5 A write to addr DEPTH (512) = 0xFFFFFFFF -> errA=1, outA=0. A read of addr 0 returns
//     its prior value unchanged.
//   6 Assert reset at clear address 100, release -> clear restarts from 0 (clearing high DEPTH more cycles).
//     Assert reset with a read in flight -> no validA pulse.

Source files
------------

// File: rtl/dual_port_ram_if.sv
// rtl/dual_port_ram_if.sv - request/response bus for both ports of dual_port_ram
//
// Purpose: bundles the port A (read/write) and port B (read-only) handshake
// signals so the RAM and its requester share one connection object.
//
// Port A: reqA, weA, addrA, dataInA, byteEnA  (requester -> RAM)
//         readyA, validA, outA, errA          (RAM -> requester)
// Port B: reqB, addrB                         (requester -> RAM)
//         readyB, validB, outB, errB          (RAM -> requester)
interface dual_port_ram_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                      reqA;
   logic                      weA;
   logic [ADDRESS_WIDTH-1:0]  addrA;
   logic [DATA_WIDTH-1:0]     dataInA;
   logic [DATA_WIDTH/8-1:0]   byteEnA;
   logic                      readyA;
   logic                      validA;
   logic [DATA_WIDTH-1:0]     outA;
   logic                      errA;

   logic                      reqB;
   logic [ADDRESS_WIDTH-1:0]  addrB;
   logic                      readyB;
   logic                      validB;
   logic [DATA_WIDTH-1:0]     outB;
   logic                      errB;

   modport master (
      output reqA, weA, addrA, dataInA, byteEnA, reqB, addrB,
      input  readyA, validA, outA, errA, readyB, validB, outB, errB
   );

   modport slave (
      input  reqA, weA, addrA, dataInA, byteEnA, reqB, addrB,
      output readyA, validA, outA, errA, readyB, validB, outB, errB
   );
endinterface

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - dual-port RAM, A read/write + B read-only, post-reset clear
//
// Purpose: word-addressed memory with byte-lane writes on port A, a read-only
// port B, 1- or 2-cycle read pipeline and a hardware zero-fill after reset.
//
// Ports:
//   clk       in   clock, everything on posedge
//   reset     in   asynchronous, active-high
//   bus       slave modport of dual_port_ram_if (port A and port B handshakes)
//   clearing  out  high while the post-reset zero-fill runs
module dual_port_ram #(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 512,
   parameter int ADDRESS_WIDTH = 32,
   parameter int READ_LATENCY  = 1
) (
   input  logic           clk,
   input  logic           reset,
   dual_port_ram_if.slave bus,
   output logic           clearing
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DEPTH);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  clr_addr_q;
   logic              ready_q;
   logic              clearing_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  inrange_a, inrange_b;
   logic                  acc_a, acc_b, wr_a;
   logic [IDX_W-1:0]      idx_a, idx_b;
   logic [DATA_WIDTH-1:0] word_a, word_b, merged_a;
   logic [DATA_WIDTH-1:0] res_a_d, res_b_d;
   logic                  err_a_d, err_b_d;

   logic                  v1a_q, e1a_q, v1b_q, e1b_q;
   logic [DATA_WIDTH-1:0] d1a_q, d1b_q;
   logic                  v2a_q, e2a_q, v2b_q, e2b_q;
   logic [DATA_WIDTH-1:0] d2a_q, d2b_q;

   // Zero-fill one word per cycle, then sit in READY until the next reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
         ready_q    <= 1'b0;
         clearing_q <= 1'b1;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_addr_q == IDX_W'(DEPTH - 1)) begin
                  state_q    <= S_READY;
                  ready_q    <= 1'b1;
                  clearing_q <= 1'b0;
               end else begin
                  clr_addr_q <= clr_addr_q + IDX_W'(1);
               end
            end
            default: begin
               state_q <= S_READY;
            end
         endcase
      end
   end

   always_comb begin
      // Full-width compare; the index is forced to 0 when out of range so the
      // array is never addressed beyond DEPTH-1.
      inrange_a = (bus.addrA < DEPTH_A);
      inrange_b = (bus.addrB < DEPTH_A);
      idx_a     = inrange_a ? bus.addrA[IDX_W-1:0] : '0;
      idx_b     = inrange_b ? bus.addrB[IDX_W-1:0] : '0;
      acc_a     = bus.reqA && ready_q;
      acc_b     = bus.reqB && ready_q;
      word_a    = mem[idx_a];
      word_b    = mem[idx_b];

      merged_a = word_a;
      for (int i = 0; i < LANES; i++) begin
         if (bus.byteEnA[i]) begin
            merged_a[8*i +: 8] = bus.dataInA[8*i +: 8];
         end
      end

      wr_a    = acc_a && bus.weA && inrange_a;
      err_a_d = !inrange_a;
      res_a_d = !inrange_a ? '0 : (bus.weA ? merged_a : word_a);

      // Same-edge A write to the word B is reading: B sees the new word.
      err_b_d = !inrange_b;
      if (!inrange_b) begin
         res_b_d = '0;
      end else if (wr_a && (idx_a == idx_b)) begin
         res_b_d = merged_a;
      end else begin
         res_b_d = word_b;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         mem[clr_addr_q] <= '0;
      end else if (wr_a) begin
         mem[idx_a] <= merged_a;
      end
   end

   // Data/err registers load only with a valid result so outputs hold
   // between pulses; only the valid bits toggle every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1a_q <= 1'b0; e1a_q <= 1'b0; d1a_q <= '0;
         v1b_q <= 1'b0; e1b_q <= 1'b0; d1b_q <= '0;
         v2a_q <= 1'b0; e2a_q <= 1'b0; d2a_q <= '0;
         v2b_q <= 1'b0; e2b_q <= 1'b0; d2b_q <= '0;
      end else begin
         v1a_q <= acc_a;
         if (acc_a) begin
            d1a_q <= res_a_d;
            e1a_q <= err_a_d;
         end
         v1b_q <= acc_b;
         if (acc_b) begin
            d1b_q <= res_b_d;
            e1b_q <= err_b_d;
         end
         v2a_q <= v1a_q;
         if (v1a_q) begin
            d2a_q <= d1a_q;
            e2a_q <= e1a_q;
         end
         v2b_q <= v1b_q;
         if (v1b_q) begin
            d2b_q <= d1b_q;
            e2b_q <= e1b_q;
         end
      end
   end

   // Any READ_LATENCY other than 2 uses the single-stage pipeline.
   assign bus.validA = (READ_LATENCY == 2) ? v2a_q : v1a_q;
   assign bus.outA   = (READ_LATENCY == 2) ? d2a_q : d1a_q;
   assign bus.errA   = (READ_LATENCY == 2) ? e2a_q : e1a_q;
   assign bus.validB = (READ_LATENCY == 2) ? v2b_q : v1b_q;
   assign bus.outB   = (READ_LATENCY == 2) ? d2b_q : d1b_q;
   assign bus.errB   = (READ_LATENCY == 2) ? e2b_q : e1b_q;
   assign bus.readyA = ready_q;
   assign bus.readyB = ready_q;
   assign clearing   = clearing_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - directed bench for dual_port_ram at latency 1 and 2
module tb_dual_port_ram;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 512;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          reqA, weA, reqB;
   logic [AW-1:0] addrA, addrB;
   logic [DW-1:0] dataInA;
   logic [3:0]    byteEnA;
   logic          clearing1, clearing2;

   int errors = 0;
   int checks = 0;

   dual_port_ram_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if1 ();
   dual_port_ram_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) if2 ();

   assign if1.reqA = reqA;   assign if2.reqA = reqA;
   assign if1.weA = weA;     assign if2.weA = weA;
   assign if1.addrA = addrA; assign if2.addrA = addrA;
   assign if1.dataInA = dataInA; assign if2.dataInA = dataInA;
   assign if1.byteEnA = byteEnA; assign if2.byteEnA = byteEnA;
   assign if1.reqB = reqB;   assign if2.reqB = reqB;
   assign if1.addrB = addrB; assign if2.addrB = addrB;

   dual_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .bus(if1), .clearing(clearing1));
   dual_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .READ_LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .bus(if2), .clearing(clearing2));

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reqA = 1'b0;
      weA  = 1'b0;
      reqB = 1'b0;
   endtask

   // Caller releases reset at a negedge; counts cycles until clearing drops.
   task automatic wait_clear(input string tag);
      int   n;
      logic saw;
      n   = 0;
      saw = 1'b0;
      while (clearing1 && n < 4 * DEPTH) begin
         @(negedge clk);
         n++;
         if (if1.validA || if1.validB || if2.validA || if2.validB) saw = 1'b1;
      end
      idle();
      checkw({tag, " clear cycles"}, DW'(n), DW'(DEPTH));
      check1({tag, " no valid while clearing"}, saw, 1'b0);
      check1({tag, " dut2 clearing"}, clearing2, 1'b0);
      check1({tag, " readyA"}, if1.readyA, 1'b1);
      check1({tag, " readyB"}, if2.readyB, 1'b1);
   endtask

   // One request per port on one edge; checks lat-1 result, then lat-2 result
   // and that the lat-1 output holds after its pulse.
   task automatic txn(input string tag, input logic ra, input logic we, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic [3:0] be, input logic rb,
                      input logic [AW-1:0] ab, input logic [DW-1:0] expa, input logic erra,
                      input logic [DW-1:0] expb, input logic errb);
      reqA = ra; weA = we; addrA = aa; dataInA = da; byteEnA = be;
      reqB = rb; addrB = ab;
      @(negedge clk);
      idle();
      check1({tag, " d1 validA"}, if1.validA, ra);
      check1({tag, " d1 validB"}, if1.validB, rb);
      if (ra) begin
         checkw({tag, " d1 outA"}, if1.outA, expa);
         check1({tag, " d1 errA"}, if1.errA, erra);
      end
      if (rb) begin
         checkw({tag, " d1 outB"}, if1.outB, expb);
         check1({tag, " d1 errB"}, if1.errB, errb);
      end
      check1({tag, " d2 validA early"}, if2.validA, 1'b0);
      check1({tag, " d2 validB early"}, if2.validB, 1'b0);
      @(negedge clk);
      check1({tag, " d2 validA"}, if2.validA, ra);
      check1({tag, " d2 validB"}, if2.validB, rb);
      if (ra) begin
         checkw({tag, " d2 outA"}, if2.outA, expa);
         check1({tag, " d2 errA"}, if2.errA, erra);
         checkw({tag, " d1 outA hold"}, if1.outA, expa);
      end
      if (rb) begin
         checkw({tag, " d2 outB"}, if2.outB, expb);
         check1({tag, " d2 errB"}, if2.errB, errb);
      end
      check1({tag, " d1 validA pulse"}, if1.validA, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      addrA = '0; addrB = '0; dataInA = '0; byteEnA = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check1("reset clearing1", clearing1, 1'b1);
      check1("reset clearing2", clearing2, 1'b1);
      check1("reset readyA", if1.readyA, 1'b0);
      check1("reset readyB", if2.readyB, 1'b0);
      check1("reset validA", if1.validA, 1'b0);
      check1("reset validB", if2.validB, 1'b0);
      checkw("reset outA", if1.outA, '0);
      checkw("reset outB", if2.outB, '0);
      check1("reset errA", if1.errA, 1'b0);
      reset = 1'b0;
      wait_clear("init");

      // Full readback, A ascending and B descending
      for (int a = 0; a < DEPTH; a++) begin
         reqA = 1'b1; addrA = AW'(a);
         reqB = 1'b1; addrB = AW'(DEPTH - 1 - a);
         @(negedge clk);
         check1("readback valid", if1.validA & if1.validB, 1'b1);
         checkw("readback data", if1.outA | if1.outB, '0);
      end
      idle();
      repeat (2) @(negedge clk);

      // Byte-lane writes
      txn("wr5 full", 1, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 32'hDEADBEEF, 0, 0, 0);
      txn("wr5 lane1", 1, 1, 5, 32'h00001200, 4'h2, 0, 0, 32'hDEAD12EF, 0, 0, 0);
      txn("rd5", 1, 0, 5, 0, 4'h0, 1, 5, 32'hDEAD12EF, 0, 32'hDEAD12EF, 0);

      // Collision bypass, full and partial lanes
      txn("coll7", 1, 1, 7, 32'hCAFEF00D, 4'hF, 1, 7, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
      txn("wr7 be0", 1, 1, 7, 32'hFFFFFFFF, 4'h0, 1, 7, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
      txn("coll511", 1, 1, 511, 32'h12345678, 4'h9, 1, 511, 32'h12000078, 0, 32'h12000078, 0);

      // Preload 0..3, then back-to-back reads on A
      for (int i = 0; i < 4; i++) begin
         txn("preload", 1, 1, AW'(i), DW'(32'h10 + i), 4'hF, 0, 0, DW'(32'h10 + i), 0, 0, 0);
      end
      reqA = 1'b1; weA = 1'b0; addrA = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) begin
            check1("b2b d1 validA", if1.validA, 1'b1);
            checkw("b2b d1 outA", if1.outA, DW'(32'h10 + k - 1));
         end else begin
            check1("b2b d1 idle", if1.validA, 1'b0);
         end
         if (k >= 2 && k <= 5) begin
            check1("b2b d2 validA", if2.validA, 1'b1);
            checkw("b2b d2 outA", if2.outA, DW'(32'h10 + k - 2));
         end else begin
            check1("b2b d2 idle", if2.validA, 1'b0);
         end
         if (k < 4) addrA = AW'(k);
         else idle();
      end

      // Out of range
      txn("wr512 oor", 1, 1, 512, 32'hFFFFFFFF, 4'hF, 1, 600, 32'h0, 1, 32'h0, 1);
      txn("rd0 after oor", 1, 0, 0, 0, 4'h0, 1, 32'h80000005, 32'h10, 0, 32'h0, 1);

      // Reset mid-clear with requests held; restart from 0
      reqA = 1'b1; weA = 1'b1; addrA = 5; dataInA = 32'hFFFFFFFF; byteEnA = 4'hF;
      reqB = 1'b1; addrB = 5;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      check1("mid-clear clearing", clearing1, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_clear("restart");
      txn("rd5 after clear", 1, 0, 5, 0, 4'h0, 1, 511, 32'h0, 0, 32'h0, 0);

      // Reset with a lat-2 read in flight
      reqA = 1'b1; weA = 1'b0; addrA = 1;
      @(negedge clk);
      idle();
      reset = 1'b1;
      check1("inflight d2 validA", if2.validA, 1'b0);
      @(negedge clk);
      check1("inflight d2 validA later", if2.validA, 1'b0);
      check1("inflight d1 validA", if1.validA, 1'b0);
      reset = 1'b0;
      wait_clear("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
